sort_run_ctrl: RTL and testbench

Run/termination controller for the bubble-sort array. It raises run_o on a start request and counts compare-swap passes. When the array reports sorted, it holds run_o for a programmable pipeline-drain interval, then pulses done_o. It also adds a pass-limit watchdog (timeout_o), an abort path, and busy/done status for the host sequencer.

---
 rtl/sort_run_ctrl.sv | 109 ++++++++++
 tb/tb_sort_run_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sort_run_ctrl.sv
// Run/termination controller for the bubble-sort array: counts compare-swap passes,
// drains the compare pipeline after sorted detection, and enforces a pass-limit watchdog.
module sort_run_ctrl #(
    parameter int N_ELEM = 8,
    parameter int DRAIN  = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             all_sorted_i,
    input  logic             pass_done_i,
    output logic             run_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] pass_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0]       DRAIN_LOAD = (DRAIN > 0) ? 8'(DRAIN - 1) : 8'd0;
    localparam logic [CNT_W:0]   PASS_LIMIT = (CNT_W + 1)'(N_ELEM);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [7:0]       drain_q, drain_d;
    logic             timeout_q, timeout_d;
    logic             limit_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Limit compare is done one bit wider so a saturated counter cannot wrap below the limit.
    assign limit_hit = pass_done_i && (({1'b0, pass_cnt_q} + 1'b1) >= PASS_LIMIT);

    always_comb begin
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        drain_d    = drain_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d    = S_RUN;
                    pass_cnt_d = '0;
                    timeout_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (pass_done_i) pass_cnt_d = sat_inc(pass_cnt_q);
                    if (all_sorted_i || limit_hit) begin
                        if (!all_sorted_i) timeout_d = 1'b1;
                        if (DRAIN > 0) begin
                            state_d = S_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (drain_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pass_cnt_q <= '0;
            drain_q    <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            drain_q    <= drain_d;
            timeout_q  <= timeout_d;
        end
    end

    // All outputs decode registered state only.
    assign run_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign busy_o     = run_o;
    assign done_o     = (state_q == S_DONE);
    assign timeout_o  = timeout_q;
    assign pass_cnt_o = pass_cnt_q;

endmodule

// File: tb/tb_sort_run_ctrl.sv
// Directed bench for sort_run_ctrl: a DRAIN=4 instance for the main sequence and a
// DRAIN=0 instance sharing the same stimulus for the no-drain and mid-job reset cases.
module tb_sort_run_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, sorted = 1'b0, pdone = 1'b0;
    logic       run4, busy4, done4, tmo4;
    logic [7:0] cnt4;
    logic       run0, busy0, done0, tmo0;
    logic [7:0] cnt0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sort_run_ctrl #(.N_ELEM(8), .DRAIN(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .all_sorted_i(sorted), .pass_done_i(pdone),
        .run_o(run4), .busy_o(busy4), .done_o(done4), .timeout_o(tmo4), .pass_cnt_o(cnt4)
    );

    sort_run_ctrl #(.N_ELEM(8), .DRAIN(0), .CNT_W(8)) dut_nodrain (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .all_sorted_i(sorted), .pass_done_i(pdone),
        .run_o(run0), .busy_o(busy0), .done_o(done0), .timeout_o(tmo0), .pass_cnt_o(cnt0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pass_pulse();
        pdone = 1'b1;
        tick();
        pdone = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_run", run4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_tmo", tmo4, 0);
        chk("rst_cnt", cnt4, 0);

        // Normal sort: start at cycle 0, passes at 5,10,15, sorted at 15
        for (int c = 0; c < 22; c++) begin
            start  = (c == 0);
            pdone  = (c == 5 || c == 10 || c == 15);
            sorted = (c == 15);
            tick();
            chk("t1_run", run4, (c + 1 >= 1 && c + 1 <= 19));
            chk("t1_busy", busy4, (c + 1 <= 19));
            chk("t1_done", done4, (c + 1 == 20));
        end
        start = 1'b0; pdone = 1'b0; sorted = 1'b0;
        chk("t1_cnt", cnt4, 3);
        chk("t1_tmo", tmo4, 0);

        // Watchdog: 8 passes with no sorted report
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_run", run4, 1);
        chk("t2_cnt0", cnt4, 0);
        for (int p = 1; p <= 8; p++) begin
            tick();
            tick();
            pass_pulse();
            if (p < 8) begin
                chk("t2_cnt", cnt4, p);
                chk("t2_tmo_early", tmo4, 0);
            end
        end
        chk("t2_tmo", tmo4, 1);
        chk("t2_cnt8", cnt4, 8);
        chk("t2_drain_run", run4, 1);
        for (int i = 0; i < 3; i++) begin
            pdone = (i == 0);
            tick();
            pdone = 1'b0;
            chk("t2_drain_run", run4, 1);
            chk("t2_drain_done", done4, 0);
        end
        tick();
        chk("t2_done_run", run4, 0);
        chk("t2_done", done4, 1);
        chk("t2_cnt_frozen", cnt4, 8);
        tick();
        chk("t2_idle_busy", busy4, 0);
        chk("t2_idle_tmo", tmo4, 1);

        // Simultaneous limit and sorted; start during RUN ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_tmo_clr", tmo4, 0);
        chk("t3_cnt_clr", cnt4, 0);
        for (int p = 1; p <= 7; p++) begin
            tick();
            pass_pulse();
            if (p == 3) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("t5_start_run_cnt", cnt4, 3);
                chk("t5_start_run_busy", busy4, 1);
            end
        end
        pdone = 1'b1; sorted = 1'b1;
        tick();
        pdone = 1'b0; sorted = 1'b0;
        chk("t3_tmo", tmo4, 0);
        chk("t3_cnt", cnt4, 8);
        chk("t3_run", run4, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_drain_done", done4, 0);
        end
        tick();
        chk("t3_done", done4, 1);
        chk("t3_tmo_end", tmo4, 0);

        // Start during DONE ignored, start the next cycle accepted
        start = 1'b1;
        tick();
        chk("t5_done_busy", busy4, 0);
        chk("t5_done_cnt", cnt4, 8);
        tick();
        start = 1'b0;
        chk("t5_accept_busy", busy4, 1);
        chk("t5_accept_cnt", cnt4, 0);

        // Abort during the second drain cycle
        pass_pulse();
        pass_pulse();
        sorted = 1'b1;
        tick();
        sorted = 1'b0;
        chk("t4_drain1", run4, 1);
        tick();
        chk("t4_drain2", run4, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_run", run4, 0);
        chk("t4_busy", busy4, 0);
        chk("t4_cnt", cnt4, 2);
        chk("t4_done", done4, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_no_done", done4, 0);
        end

        // Start blocked by simultaneous abort in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_blk_busy", busy4, 0);
        chk("t5_blk_cnt", cnt4, 2);

        // DRAIN=0 build, then reset mid-job
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_busy0", busy0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_run0", run0, 1);
        pass_pulse();
        chk("t6_cnt0", cnt0, 1);
        sorted = 1'b1;
        tick();
        chk("t6_done0", done0, 1);
        chk("t6_run0_low", run0, 0);
        chk("t6_busy0_low", busy0, 0);
        tick();
        sorted = 1'b0;
        chk("t6_done0_pulse", done0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        pass_pulse();
        pass_pulse();
        chk("t6_cnt0_mid", cnt0, 2);
        chk("t6_run0_mid", run0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_run0", run0, 0);
        chk("t6_rst_busy0", busy0, 0);
        chk("t6_rst_done0", done0, 0);
        chk("t6_rst_tmo0", tmo0, 0);
        chk("t6_rst_cnt0", cnt0, 0);
        chk("t6_rst_run4", run4, 0);
        chk("t6_rst_cnt4", cnt4, 0);
        tick();
        chk("t6_rst_nodone0", done0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
